// File: rtl/decode_stage_if.sv
// Fetch-to-execute bundle around the decode stage: instruction in, decoded control word out.
// master is the surrounding pipeline (fetch/execute side), slave is the decode stage itself.
interface decode_stage_if #(
    parameter int ADDRESS_BITS = 16
);
    logic                    in_valid;
    logic                    in_ready;
    logic [ADDRESS_BITS-1:0] in_PC;
    logic [31:0]             in_instr;
    logic                    flush;

    logic                    out_valid;
    logic                    out_ready;
    logic [ADDRESS_BITS-1:0] out_PC;
    logic [4:0]              read_sel1;
    logic [4:0]              read_sel2;
    logic [4:0]              write_sel;
    logic                    wEn;
    logic                    mem_wEn;
    logic                    wb_sel;
    logic                    branch_op;
    logic [31:0]             imm32;
    logic [1:0]              op_A_sel;
    logic                    op_B_sel;
    logic [5:0]              ALU_Control;
    logic                    illegal;

    modport master (
        output in_valid, in_PC, in_instr, flush, out_ready,
        input  in_ready, out_valid, out_PC, read_sel1, read_sel2, write_sel,
               wEn, mem_wEn, wb_sel, branch_op, imm32, op_A_sel, op_B_sel,
               ALU_Control, illegal
    );

    modport slave (
        input  in_valid, in_PC, in_instr, flush, out_ready,
        output in_ready, out_valid, out_PC, read_sel1, read_sel2, write_sel,
               wEn, mem_wEn, wb_sel, branch_op, imm32, op_A_sel, op_B_sel,
               ALU_Control, illegal
    );
endinterface

// File: rtl/decode_stage.sv
// Registered RV32I decode stage: decodes on accept into an output register, stalls one cycle
// on load-use hazards, drops everything on flush and counts inserted bubbles.
module decode_stage #(
    parameter int ADDRESS_BITS       = 16,
    parameter int ENABLE_M           = 0,
    parameter int LOAD_USE_INTERLOCK = 1,
    parameter int CNT_BITS           = 16
) (
    input  logic                clock,
    input  logic                reset,
    decode_stage_if.slave       bus,
    output logic [CNT_BITS-1:0] bubble_count
);
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;

    assign instr  = bus.in_instr;
    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign funct7 = instr[31:25];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'd0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    logic [5:0]  alu_next;
    logic [1:0]  op_a_next;
    logic        op_b_next;
    logic        wen_next;
    logic        mem_wen_next;
    logic        wb_sel_next;
    logic        branch_next;
    logic [31:0] imm_next;
    logic        illegal_next;
    logic        is_load_next;
    logic        uses_rs1;
    logic        uses_rs2;

    always_comb begin
        alu_next     = 6'd0;
        op_a_next    = 2'b00;
        op_b_next    = 1'b0;
        wen_next     = 1'b0;
        mem_wen_next = 1'b0;
        wb_sel_next  = 1'b0;
        branch_next  = 1'b0;
        imm_next     = 32'd0;
        illegal_next = 1'b0;
        is_load_next = 1'b0;
        uses_rs1     = 1'b1;
        uses_rs2     = 1'b0;
        case (opcode)
            OP_R: begin
                uses_rs2 = 1'b1;
                if (funct7 == 7'b0000000 || funct7 == 7'b0100000) begin
                    alu_next  = {1'b0, instr[30], 1'b0, funct3};
                    op_b_next = 1'b1;
                    wen_next  = 1'b1;
                end else if ((ENABLE_M != 0) && funct7 == 7'b0000001) begin
                    alu_next  = {3'b001, funct3};
                    op_b_next = 1'b1;
                    wen_next  = 1'b1;
                end else begin
                    illegal_next = 1'b1;
                end
            end
            OP_IMM: begin
                // only the shift-right immediates carry an arithmetic/logical selector in bit 30
                alu_next = (funct3 == 3'b101) ? {1'b0, instr[30], 1'b0, 3'b101} : {3'b000, funct3};
                imm_next = imm_i;
                wen_next = 1'b1;
            end
            OP_LOAD: begin
                imm_next     = imm_i;
                wen_next     = 1'b1;
                wb_sel_next  = 1'b1;
                is_load_next = 1'b1;
            end
            OP_STORE: begin
                uses_rs2     = 1'b1;
                imm_next     = imm_s;
                mem_wen_next = 1'b1;
            end
            OP_BRANCH: begin
                uses_rs2    = 1'b1;
                alu_next    = {3'b010, funct3};
                imm_next    = imm_b;
                op_b_next   = 1'b1;
                branch_next = 1'b1;
            end
            OP_JAL: begin
                uses_rs1    = 1'b0;
                alu_next    = 6'b011111;
                op_a_next   = 2'b10;
                imm_next    = imm_j;
                wen_next    = 1'b1;
                branch_next = 1'b1;
            end
            OP_JALR: begin
                alu_next    = 6'b111111;
                op_a_next   = 2'b10;
                imm_next    = imm_i;
                wen_next    = 1'b1;
                branch_next = 1'b1;
            end
            OP_AUIPC: begin
                uses_rs1  = 1'b0;
                op_a_next = 2'b01;
                imm_next  = imm_u;
                wen_next  = 1'b1;
            end
            OP_LUI: begin
                uses_rs1  = 1'b0;
                op_a_next = 2'b11;
                imm_next  = imm_u;
                wen_next  = 1'b1;
            end
            default: illegal_next = 1'b1;
        endcase
        if (rd == 5'd0) begin
            wen_next = 1'b0;
        end
    end

    logic                    out_valid_reg;
    logic [ADDRESS_BITS-1:0] out_pc_reg;
    logic [4:0]              read_sel1_reg;
    logic [4:0]              read_sel2_reg;
    logic [4:0]              write_sel_reg;
    logic                    wen_reg;
    logic                    mem_wen_reg;
    logic                    wb_sel_reg;
    logic                    branch_reg;
    logic [31:0]             imm_reg;
    logic [1:0]              op_a_reg;
    logic                    op_b_reg;
    logic [5:0]              alu_reg;
    logic                    illegal_reg;
    logic                    held_load_reg;
    logic [CNT_BITS-1:0]     bubble_cnt_reg;

    logic hazard;
    logic accept;
    logic consume;

    // the held load's destination is compared against the incoming sources still sitting on the bus
    assign hazard = (LOAD_USE_INTERLOCK != 0) & out_valid_reg & held_load_reg &
                    (write_sel_reg != 5'd0) & bus.in_valid &
                    ((uses_rs1 & (rs1 == write_sel_reg)) | (uses_rs2 & (rs2 == write_sel_reg)));

    assign bus.in_ready = (~out_valid_reg | bus.out_ready) & ~hazard & ~bus.flush;
    assign accept       = bus.in_valid & bus.in_ready;
    assign consume      = out_valid_reg & bus.out_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_valid_reg <= 1'b0;
            out_pc_reg    <= '0;
            read_sel1_reg <= 5'd0;
            read_sel2_reg <= 5'd0;
            write_sel_reg <= 5'd0;
            wen_reg       <= 1'b0;
            mem_wen_reg   <= 1'b0;
            wb_sel_reg    <= 1'b0;
            branch_reg    <= 1'b0;
            imm_reg       <= 32'd0;
            op_a_reg      <= 2'b00;
            op_b_reg      <= 1'b0;
            alu_reg       <= 6'd0;
            illegal_reg   <= 1'b0;
            held_load_reg <= 1'b0;
        end else if (bus.flush) begin
            out_valid_reg <= 1'b0;
            held_load_reg <= 1'b0;
        end else if (accept) begin
            out_valid_reg <= 1'b1;
            out_pc_reg    <= bus.in_PC;
            read_sel1_reg <= rs1;
            read_sel2_reg <= rs2;
            write_sel_reg <= rd;
            wen_reg       <= wen_next;
            mem_wen_reg   <= mem_wen_next;
            wb_sel_reg    <= wb_sel_next;
            branch_reg    <= branch_next;
            imm_reg       <= imm_next;
            op_a_reg      <= op_a_next;
            op_b_reg      <= op_b_next;
            alu_reg       <= alu_next;
            illegal_reg   <= illegal_next;
            held_load_reg <= is_load_next;
        end else if (consume) begin
            out_valid_reg <= 1'b0;
            held_load_reg <= 1'b0;
        end
    end

    // a hazard with a ready consumer is exactly the cycle the bubble is created
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bubble_cnt_reg <= '0;
        end else if (hazard && bus.out_ready && !bus.flush && !(&bubble_cnt_reg)) begin
            bubble_cnt_reg <= bubble_cnt_reg + CNT_BITS'(1);
        end
    end

    assign bus.out_valid   = out_valid_reg;
    assign bus.out_PC      = out_pc_reg;
    assign bus.read_sel1   = read_sel1_reg;
    assign bus.read_sel2   = read_sel2_reg;
    assign bus.write_sel   = write_sel_reg;
    assign bus.wEn         = wen_reg;
    assign bus.mem_wEn     = mem_wen_reg;
    assign bus.wb_sel      = wb_sel_reg;
    assign bus.branch_op   = branch_reg;
    assign bus.imm32       = imm_reg;
    assign bus.op_A_sel    = op_a_reg;
    assign bus.op_B_sel    = op_b_reg;
    assign bus.ALU_Control = alu_reg;
    assign bus.illegal     = illegal_reg;
    assign bubble_count    = bubble_cnt_reg;
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: hand-derived expectations are queued on issue and compared
// when the output side consumes; a second instance with ENABLE_M=1 runs in lockstep.
module tb_decode_stage;
    logic        clock;
    logic        reset;
    logic        in_valid;
    logic [15:0] in_PC;
    logic [31:0] in_instr;
    logic        flush;
    logic        out_ready;
    logic [15:0] bubble_count;
    logic [15:0] bubble_count_m;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    int last_cyc = 0;
    int prev_cyc = 0;
    logic [15:0] pc_next = 16'h0000;

    decode_stage_if #(.ADDRESS_BITS(16)) bus ();
    decode_stage_if #(.ADDRESS_BITS(16)) bus_m ();

    assign bus.in_valid    = in_valid;
    assign bus.in_PC       = in_PC;
    assign bus.in_instr    = in_instr;
    assign bus.flush       = flush;
    assign bus.out_ready   = out_ready;
    assign bus_m.in_valid  = in_valid;
    assign bus_m.in_PC     = in_PC;
    assign bus_m.in_instr  = in_instr;
    assign bus_m.flush     = flush;
    assign bus_m.out_ready = out_ready;

    decode_stage #(.ADDRESS_BITS(16), .ENABLE_M(0), .LOAD_USE_INTERLOCK(1), .CNT_BITS(16)) dut (
        .clock        (clock),
        .reset        (reset),
        .bus          (bus.slave),
        .bubble_count (bubble_count)
    );

    decode_stage #(.ADDRESS_BITS(16), .ENABLE_M(1), .LOAD_USE_INTERLOCK(1), .CNT_BITS(16)) dut_m (
        .clock        (clock),
        .reset        (reset),
        .bus          (bus_m.slave),
        .bubble_count (bubble_count_m)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] pc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [5:0]  alu;
        logic [1:0]  a_sel;
        logic        b_sel;
        logic [4:0]  ctl;    // {wEn, mem_wEn, wb_sel, branch_op, illegal}
        logic [5:0]  alu_m;
        logic        ill_m;
    } exp_t;

    exp_t exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    function automatic exp_t mk(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [31:0] imm, input logic [5:0] alu, input logic [1:0] a_sel,
                                input logic b_sel, input logic [4:0] ctl);
        exp_t e;
        e.pc    = 16'h0;
        e.rd    = rd;
        e.rs1   = rs1;
        e.rs2   = rs2;
        e.imm   = imm;
        e.alu   = alu;
        e.a_sel = a_sel;
        e.b_sel = b_sel;
        e.ctl   = ctl;
        e.alu_m = alu;
        e.ill_m = ctl[0];
        return e;
    endfunction

    // consumption happens at the next rising edge; sample here while inputs are stable
    always @(negedge clock) begin
        if (reset && bus.out_valid && out_ready) begin
            prev_cyc = last_cyc;
            last_cyc = cyc;
            if (exp_q.size() == 0) begin
                chk("unexpected_output", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("out_PC",    {16'd0, bus.out_PC}, {16'd0, e.pc});
                chk("write_sel", {27'd0, bus.write_sel}, {27'd0, e.rd});
                chk("read_sel1", {27'd0, bus.read_sel1}, {27'd0, e.rs1});
                chk("read_sel2", {27'd0, bus.read_sel2}, {27'd0, e.rs2});
                chk("imm32",     bus.imm32, e.imm);
                chk("ALU_Control", {26'd0, bus.ALU_Control}, {26'd0, e.alu});
                chk("wEn",       {31'd0, bus.wEn}, {31'd0, e.ctl[4]});
                chk("mem_wEn",   {31'd0, bus.mem_wEn}, {31'd0, e.ctl[3]});
                chk("branch_op", {31'd0, bus.branch_op}, {31'd0, e.ctl[1]});
                chk("illegal",   {31'd0, bus.illegal}, {31'd0, e.ctl[0]});
                if (!e.ctl[0]) begin
                    chk("wb_sel",   {31'd0, bus.wb_sel}, {31'd0, e.ctl[2]});
                    chk("op_A_sel", {30'd0, bus.op_A_sel}, {30'd0, e.a_sel});
                    chk("op_B_sel", {31'd0, bus.op_B_sel}, {31'd0, e.b_sel});
                end
                chk("ALU_Control_m", {26'd0, bus_m.ALU_Control}, {26'd0, e.alu_m});
                chk("illegal_m",     {31'd0, bus_m.illegal}, {31'd0, e.ill_m});
            end
        end
    end

    // called at posedge+1; returns at posedge+1 right after the accepting edge
    task automatic send(input logic [31:0] ins, input exp_t e);
        int n;
        e.pc     = pc_next;
        in_valid = 1'b1;
        in_PC    = pc_next;
        in_instr = ins;
        exp_q.push_back(e);
        pc_next  = pc_next + 16'd4;
        n = 0;
        @(negedge clock);
        while (!bus.in_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (n >= 20) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        exp_t e;
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_PC     = 16'h0;
        in_instr  = 32'h0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_bubble", {16'd0, bubble_count}, 32'd0);
        reset = 1'b1;
        step();
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

        // addi x1,x0,5: visible the cycle after accept
        send(32'h00500093, mk(5'd1, 5'd0, 5'd5, 32'd5, 6'h00, 2'b00, 1'b0, 5'b10000));
        @(negedge clock);
        chk("addi_latency_valid", {31'd0, bus.out_valid}, 32'd1);
        step();

        // lw x2 then dependent add x3,x2,x2: one bubble
        send(32'h0000A103, mk(5'd2, 5'd1, 5'd0, 32'd0, 6'h00, 2'b00, 1'b0, 5'b10100));
        send(32'h002101B3, mk(5'd3, 5'd2, 5'd2, 32'd0, 6'h00, 2'b00, 1'b1, 5'b10000));
        @(negedge clock);
        #1;
        chk("load_use_spacing", last_cyc - prev_cyc, 32'd2);
        chk("bubble_after_hazard", {16'd0, bubble_count}, 32'd1);
        step();

        // back-to-back stream covering the remaining opcode rows
        send(32'h4033D313, mk(5'd6, 5'd7, 5'd3, 32'h403, 6'h15, 2'b00, 1'b0, 5'b10000));
        send(32'hFFF00513, mk(5'd10, 5'd0, 5'd31, 32'hFFFFFFFF, 6'h00, 2'b00, 1'b0, 5'b10000));
        send(32'h0020A623, mk(5'd12, 5'd1, 5'd2, 32'd12, 6'h00, 2'b00, 1'b0, 5'b01000));
        send(32'h123453B7, mk(5'd7, 5'd8, 5'd3, 32'h12345000, 6'h00, 2'b11, 1'b0, 5'b10000));
        send(32'h010000EF, mk(5'd1, 5'd0, 5'd16, 32'd16, 6'h1F, 2'b10, 1'b0, 5'b10010));
        send(32'h00008067, mk(5'd0, 5'd1, 5'd0, 32'd0, 6'h3F, 2'b10, 1'b0, 5'b00010));
        send(32'hFFFFF417, mk(5'd8, 5'd31, 5'd31, 32'hFFFFF000, 6'h00, 2'b01, 1'b0, 5'b10000));
        send(32'h404184B3, mk(5'd9, 5'd3, 5'd4, 32'd0, 6'h10, 2'b00, 1'b1, 5'b10000));
        step();

        // beq x0,x0,+8 held for three cycles
        out_ready = 1'b0;
        send(32'h00000463, mk(5'd8, 5'd0, 5'd0, 32'd8, 6'h10, 2'b00, 1'b1, 5'b00010));
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            chk("hold_out_valid", {31'd0, bus.out_valid}, 32'd1);
            chk("hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
            chk("hold_imm32", bus.imm32, 32'd8);
            chk("hold_alu", {26'd0, bus.ALU_Control}, 32'h10);
        end
        step();
        out_ready = 1'b1;
        step();

        // flush while a load is held and a dependent instruction waits
        send(32'h00002203, mk(5'd4, 5'd0, 5'd0, 32'd0, 6'h00, 2'b00, 1'b0, 5'b10100));
        in_valid = 1'b1;
        in_PC    = 16'h0BAD;
        in_instr = 32'h000202B3;
        flush    = 1'b1;
        @(negedge clock);
        chk("flush_in_ready", {31'd0, bus.in_ready}, 32'd0);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clock);
        chk("flush_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("flush_bubble", {16'd0, bubble_count}, 32'd1);
        step();
        @(negedge clock);
        chk("flush_not_accepted", {31'd0, bus.out_valid}, 32'd0);
        step();

        // illegal encodings; the RV32M encoding is legal only in the ENABLE_M instance
        send(32'hFFFFFFFF, mk(5'd31, 5'd31, 5'd31, 32'd0, 6'h00, 2'b00, 1'b0, 5'b00001));
        e = mk(5'd0, 5'd1, 5'd2, 32'd0, 6'h00, 2'b00, 1'b0, 5'b00001);
        e.alu_m = 6'h08;
        e.ill_m = 1'b0;
        send(32'h02208033, e);
        step();
        step();
        chk("bubble_final", {16'd0, bubble_count}, 32'd1);

        // asynchronous reset with an instruction held
        out_ready = 1'b0;
        send(32'h00500093, mk(5'd1, 5'd0, 5'd5, 32'd5, 6'h00, 2'b00, 1'b0, 5'b10000));
        @(negedge clock);
        chk("pre_reset_valid", {31'd0, bus.out_valid}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("areset_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("areset_imm32", bus.imm32, 32'd0);
        chk("areset_write_sel", {27'd0, bus.write_sel}, 32'd0);
        chk("areset_wEn", {31'd0, bus.wEn}, 32'd0);
        chk("areset_out_PC", {16'd0, bus.out_PC}, 32'd0);
        chk("areset_bubble", {16'd0, bubble_count}, 32'd0);
        exp_q.delete();
        step();
        reset = 1'b1;
        out_ready = 1'b1;
        @(negedge clock);
        chk("post_reset_in_ready", {31'd0, bus.in_ready}, 32'd1);

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
